// File: rtl/mem_port_arbiter.sv
// Arbitrates a Y86 fetch port (two 64-bit beats -> 80-bit instruction) and a memory-stage
// port onto one shared memory bus. Optional abort timer: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic        f_done,
  output logic [79:0] f_instr,
  output logic        m_done,
  output logic [63:0] m_rdata,
  output logic        f_wait,
  output logic        m_wait,
  output logic [3:0]  f_stat,
  output logic [3:0]  m_stat,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  typedef enum logic [1:0] {IDLE, F_BEAT0, F_BEAT1, M_XFER} state_t;

  localparam logic [3:0] STAT_AOK = 4'd1;
  localparam logic [3:0] STAT_ADR = 4'd3;

  state_t      r_state;
  logic        r_last_m;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [63:0] r_mem_addr;
  logic [63:0] r_mem_wdata;
  logic        r_f_done;
  logic        r_m_done;
  logic [79:0] r_f_instr;
  logic [63:0] r_m_rdata;
  logic [3:0]  r_f_stat;
  logic [3:0]  r_m_stat;

  logic w_f_avail;
  logic w_m_avail;
  logic w_grant_m;
  logic w_grant_f;
  logic w_timeout;

  // A requester whose done is showing this cycle is still holding its old request.
  assign w_f_avail = f_req & ~r_f_done;
  assign w_m_avail = m_req & ~r_m_done;
  assign w_grant_m = w_m_avail & (~w_f_avail | ~r_last_m);
  assign w_grant_f = w_f_avail & ~w_grant_m;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [3:0] r_cnt;

  // Abort on the edge at which the wait count would reach 15.
  assign w_timeout = r_mem_req & ~mem_ack & (r_cnt == 4'd14);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= 4'd0;
    end else if (r_state == IDLE || mem_ack) begin
      r_cnt <= 4'd0;
    end else begin
      r_cnt <= r_cnt + 4'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_last_m    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 64'd0;
      r_mem_wdata <= 64'd0;
      r_f_done    <= 1'b0;
      r_m_done    <= 1'b0;
      r_f_instr   <= 80'd0;
      r_m_rdata   <= 64'd0;
      r_f_stat    <= STAT_AOK;
      r_m_stat    <= STAT_AOK;
    end else begin
      r_f_done <= 1'b0;
      r_m_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_m) begin
            r_state     <= M_XFER;
            r_last_m    <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= m_we;
            r_mem_addr  <= m_addr;
            r_mem_wdata <= m_wdata;
          end else if (w_grant_f) begin
            r_state     <= F_BEAT0;
            r_last_m    <= 1'b0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= f_addr;
            r_mem_wdata <= 64'd0;
          end
        end
        F_BEAT0: begin
          if (mem_ack && !mem_err) begin
            r_f_instr[63:0] <= mem_rdata;
            r_mem_addr      <= r_mem_addr + 64'd8;
            r_state         <= F_BEAT1;
          end else if (mem_ack || w_timeout) begin
            r_f_done  <= 1'b1;
            r_f_stat  <= STAT_ADR;
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        F_BEAT1: begin
          if (mem_ack || w_timeout) begin
            if (mem_ack && !mem_err) r_f_instr[79:64] <= mem_rdata[15:0];
            r_f_done  <= 1'b1;
            r_f_stat  <= (mem_ack && !mem_err) ? STAT_AOK : STAT_ADR;
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        M_XFER: begin
          if (mem_ack || w_timeout) begin
            if (mem_ack && !mem_err && !r_mem_we) r_m_rdata <= mem_rdata;
            r_m_done  <= 1'b1;
            r_m_stat  <= (mem_ack && !mem_err) ? STAT_AOK : STAT_ADR;
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign f_done    = r_f_done;
  assign m_done    = r_m_done;
  assign f_instr   = r_f_instr;
  assign m_rdata   = r_m_rdata;
  assign f_stat    = r_f_stat;
  assign m_stat    = r_m_stat;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign f_wait    = f_req & ~r_f_done;
  assign m_wait    = m_req & ~r_m_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: pipeline agents and a memory responder driven
// against a transaction-level model of arbitration, beats, done timing and status.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        f_req, m_req, m_we;
  logic [63:0] f_addr, m_addr, m_wdata;
  logic        f_done, m_done, f_wait, m_wait;
  logic [79:0] f_instr;
  logic [63:0] m_rdata;
  logic [3:0]  f_stat, m_stat;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .f_req(f_req), .f_addr(f_addr),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .f_done(f_done), .f_instr(f_instr), .m_done(m_done), .m_rdata(m_rdata),
    .f_wait(f_wait), .m_wait(m_wait), .f_stat(f_stat), .m_stat(m_stat),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents are a fixed function of the address.
  function automatic logic [63:0] memf(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [63:0] pick_addr();
    logic [63:0] a;
    if ($urandom % 4 == 0) a = 64'hFFFF_FFFF_FFFF_FFF8;
    else a = {$urandom, $urandom};
    return a;
  endfunction

  // Reference model: who owns the bus, which beat, what each done must deliver.
  int          owner;       // 0 none, 1 fetch, 2 memory stage
  int          beat, waitc;
  bit          last_m, exp_fd, exp_md, new_fd, new_md, fi_known, mr_known;
  bit          f_rel, m_rel, just_reset, go, err, fav, mav, lat_done;
  logic [3:0]  exp_fs, exp_ms;
  logic [79:0] exp_fi;
  logic [63:0] exp_mr, fa_l, ma_l, mw_l, a, d;
  bit          mwe_l;

  task automatic model_reset();
    owner = 0; beat = 0; waitc = 0; last_m = 0; exp_fd = 0; exp_md = 0;
    exp_fs = 4'd1; exp_ms = 4'd1; exp_fi = 80'd0; exp_mr = 64'd0;
    fi_known = 1; mr_known = 1; f_rel = 0; m_rel = 0;
  endtask

  initial begin
    reset_n = 1'b0; f_req = 0; m_req = 0; m_we = 0; f_addr = 0; m_addr = 0; m_wdata = 0;
    mem_ack = 0; mem_err = 0; mem_rdata = 0;
    model_reset();
    lat_done = 0;
    repeat (2) @(negedge clk);
    check("rst_f_instr", f_instr, 80'd0);
    check("rst_m_rdata", m_rdata, 64'd0);
    check("rst_mem_req", mem_req, 1'b0);

    for (int cyc = 0; cyc < 4000; cyc++) begin
      // ---- compare DUT against the model ----
      check("f_done", f_done, exp_fd);
      check("m_done", m_done, exp_md);
      check("f_stat", f_stat, exp_fs);
      check("m_stat", m_stat, exp_ms);
      if (exp_fd && fi_known) check("f_instr", f_instr, exp_fi);
      if (exp_md && mr_known) check("m_rdata", m_rdata, exp_mr);
      if (just_reset) begin
        check("rst_f_instr", f_instr, 80'd0);
        check("rst_m_rdata", m_rdata, 64'd0);
        just_reset = 0;
      end
      if (!lat_done && exp_fd) begin
        check("f_latency", cyc, 3);
        lat_done = 1;
      end
      check("mem_req", mem_req, owner != 0);
      if (owner == 1) begin
        a = (beat == 1) ? fa_l + 64'd8 : fa_l;
        check("f_mem_addr", mem_addr, a);
        check("f_mem_we", mem_we, 1'b0);
      end else if (owner == 2) begin
        check("m_mem_addr", mem_addr, ma_l);
        check("m_mem_we", mem_we, mwe_l);
        if (mwe_l) check("m_mem_wdata", mem_wdata, mw_l);
      end
      check("f_wait", f_wait, f_req & ~exp_fd);
      check("m_wait", m_wait, m_req & ~exp_md);

      // ---- drive next cycle and advance the model ----
      new_fd = 0; new_md = 0;
      if (cyc > 40 && $urandom % 150 == 0) begin
        reset_n = 1'b0;
        f_req = 0; m_req = 0;
        mem_ack = $urandom % 2; mem_err = 0;
        model_reset();
        just_reset = 1;
      end else begin
        reset_n = 1'b1;
        // Each requester holds through its done cycle, then releases.
        if (f_rel) begin f_req = 0; f_rel = 0; end
        if (exp_fd) f_rel = 1;
        if (!f_req && !f_rel) begin
          if (cyc == 0) begin f_req = 1; f_addr = 64'h100; end
          else if (cyc > 8 && $urandom % 3 == 0) begin f_req = 1; f_addr = pick_addr(); end
        end
        if (m_rel) begin m_req = 0; m_rel = 0; end
        if (exp_md) m_rel = 1;
        if (!m_req && !m_rel && cyc > 8 && $urandom % 3 == 0) begin
          m_req = 1; m_we = $urandom % 2; m_addr = pick_addr(); m_wdata = {$urandom, $urandom};
        end

        if (owner != 0) begin
          go  = (cyc < 8) || (waitc >= 10) || ($urandom % 3 != 0);
          err = go && (cyc >= 8) && ($urandom % 10 == 0);
          a = (owner == 2) ? ma_l : ((beat == 1) ? fa_l + 64'd8 : fa_l);
          d = memf(a);
          mem_ack = go; mem_err = err; mem_rdata = d;
          if (!go) waitc++;
          else begin
            waitc = 0;
            if (owner == 1 && beat == 0 && !err) begin
              exp_fi[63:0] = d;
              beat = 1;
            end else if (owner == 1) begin
              if (err) fi_known = 0;
              else begin exp_fi[79:64] = d[15:0]; fi_known = 1; end
              exp_fs = err ? 4'd3 : 4'd1;
              new_fd = 1; owner = 0;
            end else begin
              if (!mwe_l) begin
                if (err) mr_known = 0;
                else begin exp_mr = d; mr_known = 1; end
              end
              exp_ms = err ? 4'd3 : 4'd1;
              new_md = 1; owner = 0;
            end
          end
        end else begin
          // Stray acks while idle must be ignored.
          mem_ack = ($urandom % 4 == 0); mem_err = $urandom % 2; mem_rdata = {$urandom, $urandom};
          fav = f_req && !exp_fd;
          mav = m_req && !exp_md;
          if (mav && (!fav || !last_m)) begin
            owner = 2; last_m = 1; waitc = 0;
            ma_l = m_addr; mwe_l = m_we; mw_l = m_wdata;
          end else if (fav) begin
            owner = 1; beat = 0; last_m = 0; waitc = 0;
            fa_l = f_addr;
          end
        end
      end
      exp_fd = new_fd; exp_md = new_md;
      @(negedge clk);
    end

    // ---- memory-stage read that is never acknowledged ----
    begin
      int reqc, donec, done_at;
      reqc = 0; donec = 0; done_at = -1;
      reset_n = 0; f_req = 0; m_req = 0; mem_ack = 0; mem_err = 0;
      @(negedge clk);
      reset_n = 1; m_req = 1; m_we = 0; m_addr = 64'h300;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (m_done) begin
          donec++;
          if (done_at < 0) done_at = reqc;
          check("to_m_stat", m_stat, 4'd3);
          m_req = 0;
        end
        if (mem_req) reqc++;
      end
`ifdef MEM_ARB_TIMEOUT_EN
      check("to_req_cycles", done_at, 15);
      check("to_done_count", donec, 1);
`else
      check("nto_done_count", donec, 0);
      check("nto_mem_req", mem_req, 1'b1);
      check("nto_m_wait", m_wait, 1'b1);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 reset_n  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 f_req  in  1  fetch-stage read request, held until f_done; f_addr  in  64  fetch PC.
REQ-004 m_req  in  1  memory-stage request, held until m_done; m_we  in  1  1=write; m_addr  in  64; m_wdata  in  64.
REQ-005 f_done  out  1  one-cycle pulse, f_instr valid; f_instr  out  80  instruction bytes, byte0 in [7:0].
REQ-006 m_done  out  1  one-cycle pulse; m_rdata  out  64  read data, valid with m_done.
REQ-007 f_wait, m_wait  out  1 each  stall requests to pipeline control.
REQ-008 f_stat, m_stat  out  4 each  Y86 status, valid with the done pulse: AOK=1, ADR=3.
REQ-009 mem_req  out  1; mem_we  out  1; mem_addr  out  64; mem_wdata  out  64  shared memory port.
REQ-010 mem_ack  in  1  one-cycle completion; mem_rdata  in  64; mem_err  in  1  address error, valid with mem_ack.

Function
REQ-011 States SHALL be IDLE, F_BEAT0, F_BEAT1, M_XFER.
REQ-012 In IDLE with m_req=1, the block SHALL go to M_XFER and latch m_we/m_addr/m_wdata; this has priority over f_req.
REQ-013 In IDLE with only f_req=1, the block SHALL go to F_BEAT0 and latch f_addr.
REQ-014 Anti-starvation: if the previous grant was M and both requests are pending, the block SHALL grant F.
REQ-015 mem_req SHALL be 1 in every non-IDLE state, from the cycle after the grant until mem_ack is seen; mem_addr/mem_we/mem_wdata SHALL stay stable throughout.
REQ-016 F_BEAT0 SHALL issue a read at the latched address; on mem_ack it SHALL store mem_rdata as f_instr[63:0] and go to F_BEAT1.
REQ-017 F_BEAT1 SHALL issue a read at latched address+8, with wrap-around modulo 2^64; on mem_ack it SHALL store mem_rdata[15:0] as f_instr[79:64], pulse f_done and return to IDLE.
REQ-018 M_XFER on mem_ack SHALL pulse m_done, load m_rdata (reads only; unchanged on writes) and return to IDLE.
REQ-019 mem_err with mem_ack SHALL end the transaction immediately: done pulse, stat=ADR. In F_BEAT0 this skips F_BEAT1. Otherwise stat=AOK.
REQ-020 f_wait = f_req & ~f_done and m_wait = m_req & ~m_done; both SHALL be combinational.
REQ-021 mem_ack in IDLE SHALL be ignored.
REQ-022 A done pulse SHALL last exactly one cycle. A request still asserted in the cycle of its own done SHALL NOT be re-granted that cycle.
REQ-023 Minimum latency from request to done: M = 2 cycles, F = 3 cycles, with mem_ack returned the cycle after mem_req.

Reset
REQ-024 With reset_n=0 at a clock edge, the block SHALL enter IDLE and clear mem_req, f_done, m_done, f_instr, m_rdata and the last-grant flag; f_stat and m_stat SHALL reset to AOK.
REQ-025 Reset mid-transaction SHALL abort it with no done pulse. A mem_ack arriving after reset SHALL be ignored per REQ-021.

Configuration
REQ-026 Macro MEM_ARB_TIMEOUT_EN: when defined, a 4-bit counter SHALL clear on each grant or beat and increment each cycle mem_req=1 without mem_ack.
REQ-027 With MEM_ARB_TIMEOUT_EN defined, reaching count 15 SHALL abort the transaction: drop mem_req, pulse the owner's done with stat=ADR, go to IDLE.
REQ-028 Without the macro, no counter SHALL exist and the block SHALL wait indefinitely for mem_ack.

Verification
REQ-029 Reset then f_req=1, f_addr=0x100, ack every cycle: reads 0x100 then 0x108 -> f_done at cycle 3, f_instr={beat1[15:0],beat0}, f_stat=1.
REQ-030 f_req and m_req together, m_we=1, m_addr=0x200, m_wdata=0xDEAD -> M served first (mem_we=1), m_done, then F served; f_wait stays high until f_done.
REQ-031 mem_err=1 on F beat0, f_addr=0xFFFF_FFFF_FFFF_FFF8 -> f_done one cycle after ack, f_stat=3, no second beat; without the error, beat1 address is 0x0.
REQ-032 reset_n=0 during F_BEAT1, then a late mem_ack -> no f_done, mem_req=0, state IDLE.
REQ-033 With MEM_ARB_TIMEOUT_EN and mem_ack held 0 on an M read -> m_done with m_stat=3 after 15 cycles of mem_req; without the macro, no done after 100 cycles.
